multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle opcode decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback. Each step drives the datapath mux selects, write enables and ALUOp for one cycle. It sits between the instruction register opcode field and the shared ALU, register file, PC and unified memory, and stalls on a memory ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as always 1).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completed current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if branch condition (zero / not-zero, per ALUOp) true
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemToReg  output  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  write register: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
Link  output  1  write PC+4 into $31 (JAL)
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
ALUOp  output  4  ALU operation code, same encoding as existing control unit
FunctEn  output  1  ALU control decodes funct field (R-type execute only)
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse on an unsupported opcode
instr_done  output  1  one-cycle pulse in the final state of every instruction
state  output  4  current state, for debug

Behaviour:
- Reset (async, rst_n = 0): state = FETCH. All outputs are 0 while rst_n is low. Reset mid-instruction abandons it; no partial writes occur after reset assertion.
- Outputs are Moore, decoded combinationally from state only, except that FETCH, MEMRD and MEMWR qualify their commit signals with mem_ready.
- Every output not listed for a state is 0. ALUOp = 0000 (add) unless stated.
- FETCH: IorD = 0, MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, PCSource = 00.
  - IRWrite and PCWrite = mem_ready. Stay in FETCH while mem_ready = 0, then go to DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11 (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 or 000101 -> BRANCH
  - 000010 or 000011 -> JUMP
  - 001000, 001100, 001101, 001110, 001010, 001011, 001111 -> IMM_EX
  - any other opcode -> FETCH, with illegal_op = 1 and instr_done = 1
- MEMADR: ALUSrcA = 1, ALUSrcB = 10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1, MemRead = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegDst = 0, MemToReg = 1, RegWrite = 1, instr_done = 1. Go to FETCH.
- MEMWR: IorD = 1, MemWrite = 1 held until mem_ready. instr_done = mem_ready. Then go to FETCH.
- RTYPE_EX: ALUSrcA = 1, ALUSrcB = 00, FunctEn = 1. Go to RTYPE_WB.
- RTYPE_WB: RegDst = 1, RegWrite = 1, instr_done = 1. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, PCWriteCond = 1, PCSource = 01, instr_done = 1. ALUOp = 0100 (beq) or 0101 (bne). Go to FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. For opcode 000011 also Link = 1 and RegWrite = 1. Go to FETCH.
- IMM_EX: ALUSrcA = 1, ALUSrcB = 10. ALUOp by opcode:
  - addi 1000, andi 1100, ori 1101, xori 1110, slti 1010, sltiu 1011, lui 1111
  - Go to IMM_WB.
- IMM_WB: RegDst = 0, MemToReg = 0, RegWrite = 1, instr_done = 1. ALUOp is held from IMM_EX. Go to FETCH.
- The IR holds opcode stable from DECODE to the end of the instruction. A change in opcode during MEMRD or MEMWR wait states has no effect on the path already chosen.
- Latency with zero wait states, in cycles:
  - lw 5; sw 4; R-type 4; immediate 4
  - beq, bne, j, jal 3
  - illegal 2
- Each cycle of mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemWrite never asserts in the same cycle as MemRead.
- With MEM_WAIT_EN = 0, wait states never occur.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-lw (state = MEMRD) -> state = FETCH and all outputs 0 immediately. After release, the first cycle shows MemRead = 1, IorD = 0.
- lw, zero wait (opcode 100011, mem_ready = 1) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB shows RegWrite = 1, MemToReg = 1, RegDst = 0. instr_done pulses once.
- sw with 2 wait cycles at MEMWR -> MemWrite = 1 for 3 consecutive cycles. instr_done only in the mem_ready cycle. RegWrite never 1. Total 6 cycles.
- bne (000101) -> BRANCH state shows ALUOp = 0101, PCWriteCond = 1, PCSource = 01. Back in FETCH on cycle 4.
- jal (000011) -> JUMP shows PCWrite = 1, PCSource = 10, Link = 1, RegWrite = 1. 3 cycles total.
- Immediate sweep: 001111 (lui) -> ALUOp = 1111 in IMM_EX and IMM_WB. Opcode 111111 -> illegal_op pulses in DECODE and the FSM returns to FETCH with no RegWrite, MemWrite or PCWrite.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundles the opcode/handshake inputs and the datapath control outputs of
//   the multi-cycle MIPS sequencer.
//   master : the sequencer (takes opcode, mem_ready; drives every control)
//   slave  : the datapath side (drives opcode, mem_ready; takes controls)
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       Link;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic       FunctEn;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, Link, ALUSrcA, ALUSrcB, ALUOp, FunctEn, PCSource,
           illegal_op, instr_done, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, Link, ALUSrcA, ALUSrcB, ALUOp, FunctEn, PCSource,
           illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle MIPS sequencer: steps each instruction through fetch, decode,
//   execute, memory and writeback, driving datapath selects/enables per step.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (all outputs 0 while low)
//     bus    - multicycle_control_if.master (opcode, mem_ready in; controls,
//              illegal_op, instr_done, debug state out)
//   MEM_WAIT_EN: 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = never wait.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    IMM_EX   = 4'd10,
    IMM_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;
  logic   rdy;

  assign rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  // Immediate ALU codes; also re-used in IMM_WB since the IR holds opcode.
  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI:  return 4'b1100;
      OP_ORI:   return 4'b1101;
      OP_XORI:  return 4'b1110;
      OP_SLTI:  return 4'b1010;
      OP_SLTIU: return 4'b1011;
      OP_LUI:   return 4'b1111;
      default:  return 4'b1000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
               return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (rdy) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_R:           state_d = RTYPE_EX;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI:
                          state_d = IMM_EX;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    if (rdy) state_d = MEMWB;
      MEMWR:    if (rdy) state_d = FETCH;
      RTYPE_EX: state_d = RTYPE_WB;
      IMM_EX:   state_d = IMM_WB;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs are forced to 0 while reset is held so nothing commits during
  // an abandoned instruction, even though FETCH itself is a reading state.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.Link        = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 4'b0000;
    bus.FunctEn     = 1'b0;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;
    bus.instr_done  = 1'b0;
    bus.state       = '0;
    if (rst_n) begin
      bus.state = state_q;
      case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = rdy;
          bus.PCWrite = rdy;
        end
        DECODE: begin
          bus.ALUSrcB = 2'b11;
          if (!is_legal(bus.opcode)) begin
            bus.illegal_op = 1'b1;
            bus.instr_done = 1'b1;
          end
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        MEMWB: begin
          bus.MemToReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = rdy;
        end
        RTYPE_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.FunctEn = 1'b1;
        end
        RTYPE_WB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA     = 1'b1;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.instr_done  = 1'b1;
          bus.ALUOp       = (bus.opcode == OP_BNE) ? 4'b0101 : 4'b0100;
        end
        JUMP: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = 2'b10;
          bus.instr_done = 1'b1;
          bus.Link       = (bus.opcode == OP_JAL);
          bus.RegWrite   = (bus.opcode == OP_JAL);
        end
        IMM_EX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = imm_aluop(bus.opcode);
        end
        IMM_WB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
          bus.ALUOp      = imm_aluop(bus.opcode);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control_if bus0 ();

  multicycle_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  multicycle_control #(.MEM_WAIT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       RegDst;
    logic       RegWrite;
    logic       Link;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic       FunctEn;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       instr_done;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic rdy;
    logic junk;
  } step_t;

  step_t q[$];
  int tests = 0;
  int fails = 0;

  // Instruction classes of the reference model.
  localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_BR = 4, C_J = 5, C_IMM = 6;

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100, 6'b000101: return C_BR;
      6'b000010, 6'b000011: return C_J;
      6'b001000, 6'b001100, 6'b001101, 6'b001110,
      6'b001010, 6'b001011, 6'b001111: return C_IMM;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] imm_code(input logic [5:0] op);
    case (op)
      6'b001000: return 4'b1000;
      6'b001100: return 4'b1100;
      6'b001101: return 4'b1101;
      6'b001110: return 4'b1110;
      6'b001010: return 4'b1010;
      6'b001011: return 4'b1011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] op, input int wf, input int wm);
    int base;
    case (classify(op))
      C_LW:    base = 5 + wm;
      C_SW:    base = 4 + wm;
      C_R:     base = 4;
      C_IMM:   base = 4;
      C_BR:    base = 3;
      C_J:     base = 3;
      default: base = 2;
    endcase
    return base + wf;
  endfunction

  function automatic ctl_t get();
    ctl_t c;
    c.PCWrite     = bus.PCWrite;
    c.PCWriteCond = bus.PCWriteCond;
    c.IorD        = bus.IorD;
    c.MemRead     = bus.MemRead;
    c.MemWrite    = bus.MemWrite;
    c.IRWrite     = bus.IRWrite;
    c.MemToReg    = bus.MemToReg;
    c.RegDst      = bus.RegDst;
    c.RegWrite    = bus.RegWrite;
    c.Link        = bus.Link;
    c.ALUSrcA     = bus.ALUSrcA;
    c.ALUSrcB     = bus.ALUSrcB;
    c.ALUOp       = bus.ALUOp;
    c.FunctEn     = bus.FunctEn;
    c.PCSource    = bus.PCSource;
    c.illegal_op  = bus.illegal_op;
    c.instr_done  = bus.instr_done;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input ctl_t c, input logic rdy, input logic junk);
    step_t s;
    s.c = c; s.rdy = rdy; s.junk = junk;
    q.push_back(s);
  endtask

  // Expected per-cycle control vectors for one instruction, wf fetch waits
  // and wm memory waits; opcode is scrambled where it must not matter.
  task automatic build(input logic [5:0] op, input int wf, input int wm);
    ctl_t c;
    int cls;
    cls = classify(op);
    q.delete();
    c = '0; c.MemRead = 1'b1; c.ALUSrcB = 2'b01;
    repeat (wf) add(c, 1'b0, 1'b1);
    c.IRWrite = 1'b1; c.PCWrite = 1'b1;
    add(c, 1'b1, 1'b1);
    c = '0; c.ALUSrcB = 2'b11;
    if (cls == C_ILL) begin
      c.illegal_op = 1'b1; c.instr_done = 1'b1;
      add(c, 1'($urandom), 1'b0);
      return;
    end
    add(c, 1'($urandom), 1'b0);
    c = '0;
    case (cls)
      C_LW, C_SW: begin
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10;
        add(c, 1'($urandom), 1'b0);
        c = '0; c.IorD = 1'b1;
        if (cls == C_LW) c.MemRead = 1'b1; else c.MemWrite = 1'b1;
        repeat (wm) add(c, 1'b0, 1'b1);
        if (cls == C_SW) c.instr_done = 1'b1;
        add(c, 1'b1, 1'b0);
        if (cls == C_LW) begin
          c = '0; c.MemToReg = 1'b1; c.RegWrite = 1'b1; c.instr_done = 1'b1;
          add(c, 1'($urandom), 1'b0);
        end
      end
      C_R: begin
        c.ALUSrcA = 1'b1; c.FunctEn = 1'b1;
        add(c, 1'($urandom), 1'b0);
        c = '0; c.RegDst = 1'b1; c.RegWrite = 1'b1; c.instr_done = 1'b1;
        add(c, 1'($urandom), 1'b0);
      end
      C_BR: begin
        c.ALUSrcA = 1'b1; c.PCWriteCond = 1'b1; c.PCSource = 2'b01;
        c.instr_done = 1'b1;
        c.ALUOp = (op == 6'b000101) ? 4'b0101 : 4'b0100;
        add(c, 1'($urandom), 1'b0);
      end
      C_J: begin
        c.PCWrite = 1'b1; c.PCSource = 2'b10; c.instr_done = 1'b1;
        if (op == 6'b000011) begin c.Link = 1'b1; c.RegWrite = 1'b1; end
        add(c, 1'($urandom), 1'b0);
      end
      default: begin
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.ALUOp = imm_code(op);
        add(c, 1'($urandom), 1'b0);
        c = '0; c.RegWrite = 1'b1; c.instr_done = 1'b1; c.ALUOp = imm_code(op);
        add(c, 1'($urandom), 1'b0);
      end
    endcase
  endtask

  // Plays the queued steps (at most nmax if nmax >= 0), one per clock.
  task automatic play(input string name, input logic [5:0] op, input int nmax, output int first);
    ctl_t got;
    first = 0;
    for (int i = 0; i < q.size() && (nmax < 0 || i < nmax); i++) begin
      bus.opcode    = q[i].junk ? 6'($urandom) : op;
      bus.mem_ready = q[i].rdy;
      @(negedge clk);
      got = get();
      check($sformatf("%s_c%0d", name, i), 32'(got), 32'(q[i].c));
      if (got.instr_done && first == 0) first = i + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input int wf, input int wm);
    int first;
    build(op, wf, wm);
    play(name, op, -1, first);
    check({name, "_lat"}, 32'(first), 32'(latency(op, wf, wm)));
  endtask

  logic [5:0] ops [16] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b000101, 6'b000010, 6'b000011, 6'b001000,
                           6'b001100, 6'b001101, 6'b001110, 6'b001010,
                           6'b001011, 6'b001111, 6'b000000, 6'b100011};

  initial begin
    int d0;
    int first;
    ctl_t fwait;
    logic [5:0] op;

    bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
    bus0.opcode = 6'b100011; bus0.mem_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 32'(get()), 32'd0);
    check("reset_state", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Main DUT idles in FETCH waiting; the no-wait instance ignores mem_ready=0.
    fwait = '0; fwait.MemRead = 1'b1; fwait.ALUSrcB = 2'b01;
    d0 = 0;
    for (int i = 1; i <= 8; i++) begin
      bus.mem_ready = 1'b0;
      bus.opcode = 6'($urandom);
      @(negedge clk);
      check($sformatf("fetch_wait_%0d", i), 32'(get()), 32'(fwait));
      if (bus0.instr_done && d0 == 0) d0 = i;
      @(posedge clk); #1;
    end
    check("nowait_lw_lat", 32'(d0), 32'd5);

    do_instr("lw",   6'b100011, 0, 0);
    do_instr("sw_w2", 6'b101011, 0, 2);
    do_instr("bne",  6'b000101, 0, 0);
    do_instr("jal",  6'b000011, 0, 0);
    do_instr("lui",  6'b001111, 0, 0);
    do_instr("ill",  6'b111111, 0, 0);
    do_instr("rtype", 6'b000000, 1, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(15)];
      do_instr($sformatf("rnd%0d_op%b", n, op), op, $urandom_range(2), $urandom_range(2));
    end

    // Reset while lw waits in MEMRD.
    build(6'b100011, 0, 6);
    play("lw_rst", 6'b100011, 4, first);
    bus.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'(get()), 32'd0);
    check("midrst_state", 32'(bus.state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst_hold%0d", i), 32'(get()), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_instr("post_rst_lw", 6'b100011, 0, 0);
    do_instr("post_rst_sw", 6'b101011, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
